// File: rtl/alu_rand_driver.sv
// Random operand driver for an ALU: issues LFSR-derived A/B with a cycling opcode,
// waits a settle time, captures the ALU result and streams it out as a record.
module alu_rand_driver #(
  parameter int          NBITS         = 8,
  parameter int          NOPS          = 16,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [7:0]  A_MASK        = 8'hFF,
  parameter logic [7:0]  B_MASK        = 8'hFF,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             seed_load,
  input  logic [15:0]      seed_in,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] a_out,
  output logic [NBITS-1:0] b_out,
  output logic [2:0]       opcode_out,
  input  logic [NBITS:0]   y_in,
  input  logic             co_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [NBITS-1:0] res_a,
  output logic [NBITS-1:0] res_b,
  output logic [2:0]       res_op,
  output logic [NBITS:0]   res_y,
  output logic             res_co,
  output logic [15:0]      res_idx,
  output logic [1:0]       dbg_state
);

  // Result port handshake: a record transfers on a rising edge where res_valid
  // and res_ready are both high; res_* stay frozen while res_valid waits on res_ready.

  typedef enum logic [1:0] {IDLE, SETTLE, OUT, DONE} state_t;

  state_t      state, state_d;
  logic [15:0] lfsr, lfsr_next;
  logic [15:0] rem, idx, issue_idx;
  logic [3:0]  scnt;
  logic        issue, capture, accept;

  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
  assign issue_idx = (state == IDLE) ? 16'd0 : 16'(idx + 16'd1);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    issue   = 1'b0;
    capture = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          issue   = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (scnt == 4'd0) begin
          capture = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        // res_valid is always high in OUT, so res_ready alone completes the transfer
        if (res_ready) begin
          accept = 1'b1;
          if (rem == 16'd1) begin
            state_d = DONE;
          end else begin
            issue   = 1'b1;
            state_d = SETTLE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr       <= SEED;
      rem        <= 16'd0;
      idx        <= 16'd0;
      scnt       <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      a_out      <= '0;
      b_out      <= '0;
      opcode_out <= 3'd0;
      res_valid  <= 1'b0;
      res_a      <= '0;
      res_b      <= '0;
      res_op     <= 3'd0;
      res_y      <= '0;
      res_co     <= 1'b0;
      res_idx    <= 16'd0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) busy <= 1'b0;

      if (state == IDLE && !start && seed_load)
        lfsr <= (seed_in == 16'd0) ? 16'hACE1 : seed_in;

      if (state == SETTLE && scnt != 4'd0)
        scnt <= 4'(scnt - 4'd1);

      if (issue) begin
        a_out      <= lfsr[NBITS-1:0] & A_MASK[NBITS-1:0];
        b_out      <= lfsr[15:16-NBITS] & B_MASK[NBITS-1:0];
        opcode_out <= issue_idx[2:0];
        idx        <= issue_idx;
        rem        <= (state == IDLE) ? 16'(NOPS) : 16'(rem - 16'd1);
        scnt       <= 4'(SETTLE_CYCLES - 1);
        lfsr       <= lfsr_next;
        busy       <= 1'b1;
      end

      if (capture) begin
        res_valid <= 1'b1;
        res_a     <= a_out;
        res_b     <= b_out;
        res_op    <= opcode_out;
        res_y     <= y_in;
        res_co    <= co_in;
        res_idx   <= idx;
      end

      if (accept) res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_rand_driver.sv
// Bench for alu_rand_driver: two instances (plain and masked/slow settle) driven by a
// bench ALU, checked every cycle against a queue of records predicted from the LFSR rule.
module tb_alu_rand_driver;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [8:0]  y;
    logic        co;
    logic [15:0] idx;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, seed_load;
  logic [15:0] seed_in;
  logic        man_ready = 1'b1;
  logic        rnd_ready = 1'b1;
  int          ready_mode = 0;
  logic        res_ready;

  logic [1:0]       busy_w, done_w, valid_w, rco_w, co_w;
  logic [1:0][7:0]  a_w, b_w, ra_w, rb_w;
  logic [1:0][2:0]  op_w, rop_w;
  logic [1:0][8:0]  y_w, ry_w;
  logic [1:0][15:0] ridx_w;
  logic [1:0][1:0]  dbg_w;

  rec_t        exp_q0[$];
  rec_t        exp_q1[$];
  rec_t        last_rec[2];
  logic        have_last[2];
  logic [15:0] m_lfsr[2];
  int          runs_exp[2];
  int          done_cnt[2];
  int          lat[2];
  logic        running[2];
  int          due[2];
  logic        prev_valid[2];
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  assign res_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? rnd_ready : man_ready;

  // Bench ALU: any deterministic function of the operands will do
  function automatic logic [8:0] alu_y(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {a, 1'b0};
      3'd6:    return {b, a[0]};
      default: return {1'b1, ~a};
    endcase
  endfunction

  function automatic logic alu_co(input logic [7:0] a, input logic [7:0] b,
                                  input logic [2:0] op);
    logic [8:0] y;
    y = alu_y(a, b, op);
    return y[8] ^ (a == b);
  endfunction

  assign y_w[0]  = alu_y(a_w[0], b_w[0], op_w[0]);
  assign y_w[1]  = alu_y(a_w[1], b_w[1], op_w[1]);
  assign co_w[0] = alu_co(a_w[0], b_w[0], op_w[0]);
  assign co_w[1] = alu_co(a_w[1], b_w[1], op_w[1]);

  alu_rand_driver #(.NBITS(8), .NOPS(10), .SETTLE_CYCLES(1),
                    .A_MASK(8'hFF), .B_MASK(8'hFF), .SEED(16'hACE1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed_in(seed_in),
    .busy(busy_w[0]), .done(done_w[0]), .a_out(a_w[0]), .b_out(b_w[0]),
    .opcode_out(op_w[0]), .y_in(y_w[0]), .co_in(co_w[0]), .res_valid(valid_w[0]),
    .res_ready(res_ready), .res_a(ra_w[0]), .res_b(rb_w[0]), .res_op(rop_w[0]),
    .res_y(ry_w[0]), .res_co(rco_w[0]), .res_idx(ridx_w[0]), .dbg_state(dbg_w[0])
  );

  alu_rand_driver #(.NBITS(8), .NOPS(3), .SETTLE_CYCLES(3),
                    .A_MASK(8'h0F), .B_MASK(8'h13), .SEED(16'hACE1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed_in(seed_in),
    .busy(busy_w[1]), .done(done_w[1]), .a_out(a_w[1]), .b_out(b_w[1]),
    .opcode_out(op_w[1]), .y_in(y_w[1]), .co_in(co_w[1]), .res_valid(valid_w[1]),
    .res_ready(res_ready), .res_a(ra_w[1]), .res_b(rb_w[1]), .res_op(rop_w[1]),
    .res_y(ry_w[1]), .res_co(rco_w[1]), .res_idx(ridx_w[1]), .dbg_state(dbg_w[1])
  );

  function automatic int nops_of(input int d);
    return (d == 0) ? 10 : 3;
  endfunction
  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction
  function automatic logic [7:0] a_mask_of(input int d);
    return (d == 0) ? 8'hFF : 8'h0F;
  endfunction
  function automatic logic [7:0] b_mask_of(input int d);
    return (d == 0) ? 8'hFF : 8'h13;
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction
  function automatic rec_t q_front(input int d);
    return (d == 0) ? exp_q0[0] : exp_q1[0];
  endfunction
  task automatic q_push(input int d, input rec_t r);
    if (d == 0) exp_q0.push_back(r);
    else        exp_q1.push_back(r);
  endtask
  task automatic q_pop(input int d);
    rec_t r;
    if (d == 0) r = exp_q0.pop_front();
    else        r = exp_q1.pop_front();
    last_rec[d]  = r;
    have_last[d] = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic finish_up();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  // Predict every record of one run from the current seed
  task automatic gen_run(input int d);
    logic [15:0] l;
    rec_t        r;
    l = m_lfsr[d];
    for (int k = 0; k < nops_of(d); k++) begin
      r.a   = l[7:0] & a_mask_of(d);
      r.b   = l[15:8] & b_mask_of(d);
      r.op  = 3'(k % 8);
      r.y   = alu_y(r.a, r.b, r.op);
      r.co  = alu_co(r.a, r.b, r.op);
      r.idx = 16'(k);
      q_push(d, r);
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    end
    m_lfsr[d] = l;
  endtask

  task automatic compare_dut(input int d);
    rec_t  e;
    logic  exp_done, exp_busy;
    string p;
    p = $sformatf("d%0d", d);
    lat[d]++;
    exp_done = (due[d] == 1);
    exp_busy = running[d] && !exp_done;
    if (due[d] > 0) due[d]--;
    if (exp_done) running[d] = 1'b0;
    chk({p, " done"}, 32'(done_w[d]), 32'(exp_done));
    chk({p, " busy"}, 32'(busy_w[d]), 32'(exp_busy));
    if (done_w[d]) done_cnt[d]++;
    if (valid_w[d]) begin
      if (q_size(d) == 0) begin
        fail_now({p, " unexpected record"});
      end else begin
        e = q_front(d);
        chk({p, " res_a"},   32'(ra_w[d]),   32'(e.a));
        chk({p, " res_b"},   32'(rb_w[d]),   32'(e.b));
        chk({p, " res_op"},  32'(rop_w[d]),  32'(e.op));
        chk({p, " res_y"},   32'(ry_w[d]),   32'(e.y));
        chk({p, " res_co"},  32'(rco_w[d]),  32'(e.co));
        chk({p, " res_idx"}, 32'(ridx_w[d]), 32'(e.idx));
        chk({p, " a_out"},   32'(a_w[d]),    32'(e.a));
        chk({p, " b_out"},   32'(b_w[d]),    32'(e.b));
        chk({p, " op_out"},  32'(op_w[d]),   32'(e.op));
        if (!prev_valid[d]) chk({p, " latency"}, 32'(lat[d]), 32'(settle_of(d) + 1));
        if (res_ready) begin
          if (q_size(d) == 1) due[d] = 2;
          else                lat[d] = 0;
          q_pop(d);
        end
      end
    end else if (busy_w[d] && q_size(d) > 0) begin
      e = q_front(d);
      chk({p, " a_out settle"},  32'(a_w[d]),  32'(e.a));
      chk({p, " b_out settle"},  32'(b_w[d]),  32'(e.b));
      chk({p, " op_out settle"}, 32'(op_w[d]), 32'(e.op));
    end else if (!busy_w[d] && have_last[d]) begin
      chk({p, " a_out idle"},  32'(a_w[d]),  32'(last_rec[d].a));
      chk({p, " b_out idle"},  32'(b_w[d]),  32'(last_rec[d].b));
      chk({p, " op_out idle"}, 32'(op_w[d]), 32'(last_rec[d].op));
    end
    prev_valid[d] = valid_w[d];
    if (!busy_w[d] && start) begin
      running[d] = 1'b1;
      lat[d]     = 0;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        lat[d] = 0; running[d] = 1'b0; due[d] = 0; prev_valid[d] = 1'b0;
      end else begin
        compare_dut(d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_check();
    for (int d = 0; d < 2; d++) begin
      string p;
      p = $sformatf("d%0d rst", d);
      chk({p, " busy"},  32'(busy_w[d]),  0);
      chk({p, " done"},  32'(done_w[d]),  0);
      chk({p, " a"},     32'(a_w[d]),     0);
      chk({p, " b"},     32'(b_w[d]),     0);
      chk({p, " op"},    32'(op_w[d]),    0);
      chk({p, " valid"}, 32'(valid_w[d]), 0);
      chk({p, " res_a"}, 32'(ra_w[d]),    0);
      chk({p, " res_b"}, 32'(rb_w[d]),    0);
      chk({p, " res_op"},32'(rop_w[d]),   0);
      chk({p, " res_y"}, 32'(ry_w[d]),    0);
      chk({p, " res_co"},32'(rco_w[d]),   0);
      chk({p, " idx"},   32'(ridx_w[d]),  0);
      chk({p, " state"}, 32'(dbg_w[d]),   0);
    end
  endtask

  task automatic do_seed(input logic [15:0] s);
    seed_in   = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    for (int d = 0; d < 2; d++) m_lfsr[d] = (s == 16'd0) ? 16'hACE1 : s;
  endtask

  task automatic do_start();
    for (int d = 0; d < 2; d++) begin
      gen_run(d);
      runs_exp[d]++;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(busy_w == 2'b00 && q_size(0) == 0 && q_size(1) == 0 &&
             due[0] == 0 && due[1] == 0) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      fail_now("timeout waiting for idle");
      finish_up();
    end
    tick();
  endtask

  task automatic wait_valid_idx(input logic [15:0] want);
    int n;
    n = 0;
    while (!(valid_w[0] && ridx_w[0] == want) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      fail_now("timeout waiting for record");
      finish_up();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; seed_load = 1'b0; seed_in = 16'd0;
    for (int d = 0; d < 2; d++) begin
      m_lfsr[d] = 16'hACE1; runs_exp[d] = 0; done_cnt[d] = 0; have_last[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    reset_check();
    rst = 1'b0;
    tick();

    // Known seed: first three vectors are hand-computed
    do_seed(16'h0001);
    do_start();
    chk("model v0 a", 32'(exp_q0[0].a), 32'h01);
    chk("model v0 b", 32'(exp_q0[0].b), 32'h00);
    chk("model v1 b", 32'(exp_q0[1].b), 32'hB4);
    chk("model v1 op", 32'(exp_q0[1].op), 1);
    chk("model v2 b", 32'(exp_q0[2].b), 32'h5A);
    chk("model v2 op", 32'(exp_q0[2].op), 2);
    chk("model v8 op", 32'(exp_q0[8].op), 0);
    wait_idle();

    // Backpressure on record 1 for five cycles
    ready_mode = 2;
    man_ready  = 1'b1;
    do_start();
    wait_valid_idx(16'd1);
    man_ready = 1'b0;
    repeat (5) tick();
    man_ready = 1'b1;
    wait_idle();

    // Zero seed maps to ACE1; start/seed_load mid-run are ignored
    ready_mode = 1;
    do_seed(16'h0000);
    do_start();
    chk("model seed0 a", 32'(exp_q0[0].a), 32'hE1);
    chk("model seed0 b", 32'(exp_q0[0].b), 32'hAC);
    repeat (2) tick();
    start = 1'b1; seed_load = 1'b1; seed_in = 16'h1234;
    tick();
    start = 1'b0; seed_load = 1'b0;
    wait_idle();

    // Masked instance with all-ones seed
    do_seed(16'hFFFF);
    do_start();
    chk("model mask a", 32'(exp_q1[0].a), 32'h0F);
    chk("model mask b", 32'(exp_q1[0].b), 32'h13);
    wait_idle();

    for (int r = 0; r < 4; r++) begin
      do_seed(16'($urandom));
      do_start();
      wait_idle();
    end

    // Asynchronous reset while a record is waiting
    ready_mode = 2;
    man_ready  = 1'b0;
    do_start();
    wait_valid_idx(16'd0);
    #1 rst = 1'b1;
    #1 reset_check();
    exp_q0.delete();
    exp_q1.delete();
    for (int d = 0; d < 2; d++) begin
      have_last[d] = 1'b0;
      m_lfsr[d]    = 16'hACE1;
      runs_exp[d]--;
    end
    tick();
    rst = 1'b0;
    ready_mode = 0;
    tick();
    do_start();
    wait_idle();

    for (int d = 0; d < 2; d++)
      chk($sformatf("d%0d done count", d), 32'(done_cnt[d]), 32'(runs_exp[d]));
    finish_up();
  end

endmodule

// File: doc/alu_rand_driver.md
Name: alu_rand_driver

Overview:
- Initiator side of the ALU operand interface: generates pseudo-random operand pairs A/B plus a cycling 3-bit opcode and drives them into the ALU.
- Waits a programmable settle time, captures the ALU result (Y, co) and streams a result record out over a valid/ready port for checking or logging.
- Sits in front of the ALU in on-chip self-test and in benches, replacing hand-written random stimulus.

Parameters:
- NBITS, 8, operand width; legal range 1..8; Y width is NBITS+1.
- NOPS, 16, vectors issued per start; legal range 1..65535.
- SETTLE_CYCLES, 1, clock edges operands are held before capture; legal range 1..15.
- A_MASK, 8'hFF, AND mask applied to the operand A value (low NBITS used).
- B_MASK, 8'hFF, AND mask applied to the operand B value (low NBITS used).
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock, all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled in IDLE only
- seed_load  in  1  load seed_in into the LFSR; honoured in IDLE only
- seed_in  in  16  new seed; 0 is replaced by 16'hACE1
- busy  out  1  high from the start edge until DONE is exited
- done  out  1  one-cycle pulse after the last record handshakes
- a_out  out  NBITS  operand A to the ALU (registered)
- b_out  out  NBITS  operand B to the ALU (registered)
- opcode_out  out  3  opcode to the ALU (registered)
- y_in  in  NBITS+1  ALU result
- co_in  in  1  ALU carry out
- res_valid  out  1  result record valid
- res_ready  in  1  consumer accepts the record
- res_a, res_b  out  NBITS each  echo of the operands used
- res_op  out  3  echo of the opcode used
- res_y  out  NBITS+1  captured y_in
- res_co  out  1  captured co_in
- res_idx  out  16  vector index, starting at 0

Behaviour:
- Reset values: all outputs 0, lfsr=SEED, state=IDLE, counters 0. Reset mid-run aborts immediately; no done pulse is produced.
- LFSR: 16-bit Galois, right shift; if lsb=1, next=(L>>1)^16'hB400, else next=L>>1.
  - Vector k uses the current L: A=L[NBITS-1:0]&A_MASK, B=L[15:16-NBITS]&B_MASK.
  - The LFSR steps once each time a vector is issued.
- Opcode: vector k uses k mod 8, wrapping 7->0.
- States: IDLE, SETTLE, OUT, DONE.
- IDLE:
  - On start=1: issue vector 0, meaning a/b/opcode_out are registered, the LFSR steps, rem=NOPS, idx=0, scnt=SETTLE_CYCLES-1, busy=1, go to SETTLE.
  - Otherwise, if seed_load=1, load the LFSR.
  - If start and seed_load are both high, start wins and the seed is ignored.
- SETTLE:
  - If scnt!=0, decrement it.
  - Else capture y_in, co_in and the operand echoes into res_*, set res_valid=1, go to OUT.
  - Result: SETTLE_CYCLES=1 gives res_valid high 2 edges after the start edge.
- OUT:
  - Hold res_* stable while res_valid=1 and res_ready=0.
  - On res_valid&&res_ready: res_valid=0. If rem==1, go to DONE. Otherwise rem--, idx++, issue the next vector, reload scnt, go to SETTLE.
- DONE: done=1 for exactly one cycle, busy=0 at the same edge, go to IDLE. a/b/opcode_out keep their last values.
- While busy: start and seed_load are ignored.
- res_ready is a don't-care while res_valid=0.
- Width: res_y is taken verbatim from y_in with no truncation.

Test Plan:
- Reset, then seed_load with seed_in=16'h0001, then start with NOPS=3, masks FF, NBITS=8, SETTLE=1 -> vectors (A,B,op) = (01,00,0), (00,B4,1), (00,5A,2); 3 records with res_idx 0,1,2; done pulses once; busy low afterwards.
- Latency: same setup, res_ready held high -> res_valid rises 2 edges after the start edge; each subsequent record arrives 2 edges after the previous handshake.
- Backpressure: hold res_ready=0 for 5 cycles on record 1 -> res_* unchanged and a_out unchanged; no LFSR step until the handshake.
- Masks A_MASK=8'h0F, B_MASK=8'h13 with seed 16'hFFFF -> A=0F, B=13 on vector 0; all later A<=0F and B only has bits from 0x13.
- seed_load with seed_in=0 -> vector 0 is A=E1, B=AC; assert start during a run -> no effect; opcode wraps 7->0 on vector 8 with NOPS=10.
- Assert rst during OUT -> all outputs 0 immediately (async); no done pulse; a new start works normally.
